// File: rtl/servo_multi.sv
// Multi-channel servo PWM generator with a shared frame counter.
// Targets are clamped on write; applied widths move only at frame boundaries.
module servo_multi #(
  parameter int NCH        = 4,
  parameter int CW         = 20,
  parameter int PERIOD     = 500000,
  parameter int MIN_PULSE  = 25000,
  parameter int MAX_PULSE  = 50000,
  parameter int INIT_PULSE = 37500,
  parameter int STEP       = 0,
  localparam int WW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [WW-1:0]  wr_ch,
  input  logic [CW-1:0]  wr_duty,
  input  logic [NCH-1:0] enable,
  output logic [NCH-1:0] pwm_out,
  output logic           frame_start,
  output logic [NCH-1:0] busy
);

  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] MINP  = CW'(MIN_PULSE);
  localparam logic [CW-1:0] MAXP  = CW'(MAX_PULSE);
  localparam logic [CW-1:0] INITP = CW'(INIT_PULSE);
  localparam logic [CW-1:0] STEPV = CW'(STEP);
  localparam logic [WW:0]   NCHV  = (WW + 1)'(NCH);

  logic [CW-1:0] cnt;
  logic [CW-1:0] tgt [NCH];
  logic [CW-1:0] cur [NCH];
  logic [CW-1:0] nxt [NCH];
  logic [CW-1:0] duty_c;
  logic          wrap;
  logic          wr_ok;

  always_comb begin
    wrap  = (cnt == LAST);
    wr_ok = wr_en && ({1'b0, wr_ch} < NCHV);
    if (wr_duty < MINP)
      duty_c = MINP;
    else if (wr_duty > MAXP)
      duty_c = MAXP;
    else
      duty_c = wr_duty;
  end

  // Slew step: never overshoots, never wraps below zero
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      nxt[i] = cur[i];
      if (STEP == 0)
        nxt[i] = tgt[i];
      else if (tgt[i] > cur[i])
        nxt[i] = (tgt[i] - cur[i] > STEPV) ? cur[i] + STEPV : tgt[i];
      else if (cur[i] > tgt[i])
        nxt[i] = (cur[i] - tgt[i] > STEPV) ? cur[i] - STEPV : tgt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++)
      busy[i] = (cur[i] != tgt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        tgt[i] <= INITP;
        cur[i] <= INITP;
      end
    end else begin
      cnt         <= wrap ? '0 : cnt + CW'(1);
      frame_start <= (cnt == '0);
      for (int i = 0; i < NCH; i++) begin
        pwm_out[i] <= enable[i] && (cnt < cur[i]);
        if (wrap)
          cur[i] <= nxt[i];
        if (wr_ok && (wr_ch == WW'(i)))
          tgt[i] <= duty_c;
      end
    end
  end

endmodule
